register_fetch_stage: RTL and testbench

Register fetch stage of the integer pipeline: owns the 32-entry architectural register file (2 read ports, 1 write port), accepts decoded instructions from the decode stage, reads both source operands and holds them in the decode/execute pipeline register. Its outputs feed the execution unit's bypass controller directly: source register indices and register-file operands, which the bypass controller then overrides with in-flight ALU, commit or write-back results. The write-back stage writes results into the register file through this stage. While an instruction is held in a stall, its captured operands stay coherent with register-file writes.

---
 rtl/register_fetch_stage_if.sv | 55 +++++
 rtl/register_fetch_stage.sv | 109 ++++++++++
 tb/tb_register_fetch_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/register_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : register_fetch_stage_if
// Description : Decode, write-back and issue bundle of the register fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_fetch_stage_if #(
    parameter int XLEN      = 32,
    parameter int UOP_WIDTH = 8
);
    logic                 flush_i;
    logic                 stall_i;

    logic                 decode_valid_i;
    logic                 decode_ready_o;
    logic [4:0]           decode_reg_src_A_i;
    logic [4:0]           decode_reg_src_B_i;
    logic [4:0]           decode_reg_dest_i;
    logic [XLEN-1:0]      decode_immediate_i;
    logic [UOP_WIDTH-1:0] decode_uop_i;

    logic                 writeback_write_i;
    logic [4:0]           writeback_reg_dest_i;
    logic [XLEN-1:0]      writeback_data_i;

    logic                 issue_valid_o;
    logic [4:0]           reg_src_A_o;
    logic [4:0]           reg_src_B_o;
    logic [XLEN-1:0]      operand_A_o;
    logic [XLEN-1:0]      operand_B_o;
    logic [4:0]           reg_dest_o;
    logic [XLEN-1:0]      immediate_o;
    logic [UOP_WIDTH-1:0] uop_o;

    modport master (
        output flush_i, stall_i,
        output decode_valid_i, decode_reg_src_A_i, decode_reg_src_B_i,
        output decode_reg_dest_i, decode_immediate_i, decode_uop_i,
        output writeback_write_i, writeback_reg_dest_i, writeback_data_i,
        input  decode_ready_o,
        input  issue_valid_o, reg_src_A_o, reg_src_B_o, operand_A_o, operand_B_o,
        input  reg_dest_o, immediate_o, uop_o
    );

    modport slave (
        input  flush_i, stall_i,
        input  decode_valid_i, decode_reg_src_A_i, decode_reg_src_B_i,
        input  decode_reg_dest_i, decode_immediate_i, decode_uop_i,
        input  writeback_write_i, writeback_reg_dest_i, writeback_data_i,
        output decode_ready_o,
        output issue_valid_o, reg_src_A_o, reg_src_B_o, operand_A_o, operand_B_o,
        output reg_dest_o, immediate_o, uop_o
    );
endinterface
`default_nettype wire

// File: rtl/register_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : register_fetch_stage
// Description : 32x XLEN register file plus decode/execute pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module register_fetch_stage #(
    parameter int XLEN      = 32,
    parameter int UOP_WIDTH = 8
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    register_fetch_stage_if.slave bus
);

    // Entry 0 is never written, so it stays at its reset value of zero.
    logic [XLEN-1:0]      r_regs [0:31];

    logic                 r_valid;
    logic [4:0]           r_src_a;
    logic [4:0]           r_src_b;
    logic [XLEN-1:0]      r_op_a;
    logic [XLEN-1:0]      r_op_b;
    logic [4:0]           r_dest;
    logic [XLEN-1:0]      r_imm;
    logic [UOP_WIDTH-1:0] r_uop;

    logic                 w_wb_en;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_drain;
    logic [XLEN-1:0]      w_rd_a;
    logic [XLEN-1:0]      w_rd_b;

    assign w_wb_en  = bus.writeback_write_i && (bus.writeback_reg_dest_i != 5'd0);
    assign w_ready  = !rst_i && (!r_valid || !bus.stall_i);
    assign w_accept = bus.decode_valid_i && w_ready && !bus.flush_i;
    assign w_drain  = r_valid && !bus.stall_i;

    // Same-cycle write-back is forwarded so a read never sees stale data.
    always_comb begin
        w_rd_a = r_regs[bus.decode_reg_src_A_i];
        if (bus.decode_reg_src_A_i == 5'd0)
            w_rd_a = '0;
        else if (w_wb_en && (bus.writeback_reg_dest_i == bus.decode_reg_src_A_i))
            w_rd_a = bus.writeback_data_i;
    end

    always_comb begin
        w_rd_b = r_regs[bus.decode_reg_src_B_i];
        if (bus.decode_reg_src_B_i == 5'd0)
            w_rd_b = '0;
        else if (w_wb_en && (bus.writeback_reg_dest_i == bus.decode_reg_src_B_i))
            w_rd_b = bus.writeback_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++)
                r_regs[i] <= '0;
        end else if (w_wb_en) begin
            r_regs[bus.writeback_reg_dest_i] <= bus.writeback_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_src_a <= '0;
            r_src_b <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_dest  <= '0;
            r_imm   <= '0;
            r_uop   <= '0;
        end else if (bus.flush_i) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_src_a <= bus.decode_reg_src_A_i;
            r_src_b <= bus.decode_reg_src_B_i;
            r_op_a  <= w_rd_a;
            r_op_b  <= w_rd_b;
            r_dest  <= bus.decode_reg_dest_i;
            r_imm   <= bus.decode_immediate_i;
            r_uop   <= bus.decode_uop_i;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            // Stalled: keep captured operands coherent with the register file.
            if (w_wb_en && (bus.writeback_reg_dest_i == r_src_a))
                r_op_a <= bus.writeback_data_i;
            if (w_wb_en && (bus.writeback_reg_dest_i == r_src_b))
                r_op_b <= bus.writeback_data_i;
        end
    end

    assign bus.decode_ready_o = w_ready;
    assign bus.issue_valid_o  = r_valid;
    assign bus.reg_src_A_o    = r_src_a;
    assign bus.reg_src_B_o    = r_src_b;
    assign bus.operand_A_o    = r_op_a;
    assign bus.operand_B_o    = r_op_b;
    assign bus.reg_dest_o     = r_dest;
    assign bus.immediate_o    = r_imm;
    assign bus.uop_o          = r_uop;

endmodule
`default_nettype wire

// File: tb/tb_register_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_fetch_stage
// Description : Directed self-checking bench for register_fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_fetch_stage;

    localparam int XLEN      = 32;
    localparam int UOP_WIDTH = 8;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    register_fetch_stage_if #(.XLEN(XLEN), .UOP_WIDTH(UOP_WIDTH)) bus ();

    register_fetch_stage #(.XLEN(XLEN), .UOP_WIDTH(UOP_WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] dest, input logic [31:0] data);
        bus.writeback_write_i    = en;
        bus.writeback_reg_dest_i = dest;
        bus.writeback_data_i     = data;
    endtask

    task automatic dec(input logic v, input logic [4:0] sa, input logic [4:0] sb,
                       input logic [4:0] d, input logic [31:0] imm, input logic [7:0] uop);
        bus.decode_valid_i     = v;
        bus.decode_reg_src_A_i = sa;
        bus.decode_reg_src_B_i = sb;
        bus.decode_reg_dest_i  = d;
        bus.decode_immediate_i = imm;
        bus.decode_uop_i       = uop;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;
        dec(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 8'h0);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        tick();
        check("rst_valid", {31'd0, bus.issue_valid_o}, 32'd0);
        check("rst_ready", {31'd0, bus.decode_ready_o}, 32'd0);
        check("rst_opA", bus.operand_A_o, 32'h0);
        check("rst_dest", {27'd0, bus.reg_dest_o}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_idle", {31'd0, bus.decode_ready_o}, 32'd1);

        // Write x5, then read it the next cycle from the register file.
        wb(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        dec(1'b1, 5'd5, 5'd0, 5'd9, 32'h11, 8'h22);
        tick();
        dec(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 8'h0);
        check("rd_valid", {31'd0, bus.issue_valid_o}, 32'd1);
        check("rd_opA", bus.operand_A_o, 32'hDEADBEEF);
        check("rd_opB", bus.operand_B_o, 32'h0);
        check("rd_dest", {27'd0, bus.reg_dest_o}, 32'd9);
        check("rd_imm", bus.immediate_o, 32'h11);
        check("rd_uop", {24'd0, bus.uop_o}, 32'h22);
        tick();
        check("drain_valid", {31'd0, bus.issue_valid_o}, 32'd0);

        // Same-cycle write-before-read on both ports.
        wb(1'b1, 5'd7, 32'h12345678);
        dec(1'b1, 5'd7, 5'd7, 5'd1, 32'h0, 8'h0);
        tick();
        check("wbr_opA", bus.operand_A_o, 32'h12345678);
        check("wbr_opB", bus.operand_B_o, 32'h12345678);

        // Write to x0 is dropped; x7 now comes from the register file itself.
        wb(1'b1, 5'd0, 32'hFFFFFFFF);
        dec(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 8'h0);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        dec(1'b1, 5'd0, 5'd7, 5'd2, 32'h0, 8'h0);
        tick();
        check("x0_opA", bus.operand_A_o, 32'h0);
        check("x7_opB", bus.operand_B_o, 32'h12345678);

        // Stall with write-back into the held operand.
        wb(1'b1, 5'd3, 32'h1);
        dec(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 8'h0);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        dec(1'b1, 5'd3, 5'd5, 5'd4, 32'h33, 8'h44);
        tick();
        check("stl_opA0", bus.operand_A_o, 32'h1);
        bus.stall_i = 1'b1;
        dec(1'b1, 5'd6, 5'd6, 5'd12, 32'h99, 8'h99);
        #1;
        check("stl_ready", {31'd0, bus.decode_ready_o}, 32'd0);
        tick();
        check("stl_valid1", {31'd0, bus.issue_valid_o}, 32'd1);
        check("stl_src1", {27'd0, bus.reg_src_A_o}, 32'd3);
        wb(1'b1, 5'd3, 32'hA5A5A5A5);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("stl_opA_upd", bus.operand_A_o, 32'hA5A5A5A5);
        check("stl_opB", bus.operand_B_o, 32'hDEADBEEF);
        check("stl_dest", {27'd0, bus.reg_dest_o}, 32'd4);
        check("stl_imm", bus.immediate_o, 32'h33);
        check("stl_uop", {24'd0, bus.uop_o}, 32'h44);
        check("stl_srcB", {27'd0, bus.reg_src_B_o}, 32'd5);
        tick();
        check("stl_hold_opA", bus.operand_A_o, 32'hA5A5A5A5);
        // Release stall: drain and accept on the same edge.
        bus.stall_i = 1'b0;
        dec(1'b1, 5'd3, 5'd7, 5'd10, 32'h55, 8'h66);
        #1;
        check("rel_ready", {31'd0, bus.decode_ready_o}, 32'd1);
        tick();
        check("swap_valid", {31'd0, bus.issue_valid_o}, 32'd1);
        check("swap_opA", bus.operand_A_o, 32'hA5A5A5A5);
        check("swap_opB", bus.operand_B_o, 32'h12345678);
        check("swap_dest", {27'd0, bus.reg_dest_o}, 32'd10);

        // Full-throughput stream of four instructions.
        for (int i = 0; i < 4; i++) begin
            dec(1'b1, 5'd5, 5'd3, 5'(16 + i), 32'h100 * i + i, 8'(i));
            #1;
            check("str_ready", {31'd0, bus.decode_ready_o}, 32'd1);
            tick();
            check("str_valid", {31'd0, bus.issue_valid_o}, 32'd1);
            check("str_dest", {27'd0, bus.reg_dest_o}, 32'(16 + i));
            check("str_imm", bus.immediate_o, 32'h100 * i + i);
            check("str_uop", {24'd0, bus.uop_o}, 32'(i));
        end
        dec(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 8'h0);
        tick();
        check("str_end", {31'd0, bus.issue_valid_o}, 32'd0);

        // Flush beats stall and suppresses the concurrent accept.
        dec(1'b1, 5'd5, 5'd0, 5'd20, 32'h20, 8'h20);
        tick();
        check("fl_pre", {31'd0, bus.issue_valid_o}, 32'd1);
        bus.stall_i = 1'b1;
        bus.flush_i = 1'b1;
        dec(1'b1, 5'd7, 5'd0, 5'd21, 32'h21, 8'h21);
        tick();
        check("fl_valid", {31'd0, bus.issue_valid_o}, 32'd0);
        check("fl_nocap", {31'd0, bus.reg_dest_o == 5'd21}, 32'd0);
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        tick();
        check("fl_resume_v", {31'd0, bus.issue_valid_o}, 32'd1);
        check("fl_resume_d", {27'd0, bus.reg_dest_o}, 32'd21);

        // Asynchronous reset mid-cycle while an instruction is held.
        bus.stall_i = 1'b1;
        dec(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 8'h0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("ar_valid", {31'd0, bus.issue_valid_o}, 32'd0);
        check("ar_opA", bus.operand_A_o, 32'h0);
        check("ar_dest", {27'd0, bus.reg_dest_o}, 32'd0);
        check("ar_imm", bus.immediate_o, 32'h0);
        check("ar_ready", {31'd0, bus.decode_ready_o}, 32'd0);
        #1;
        rst = 1'b0;
        bus.stall_i = 1'b0;
        dec(1'b1, 5'd5, 5'd7, 5'd1, 32'h0, 8'h0);
        tick();
        dec(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 8'h0);
        check("ar_rf_x5", bus.operand_A_o, 32'h0);
        check("ar_rf_x7", bus.operand_B_o, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
